// File: rtl/mem_region_ctrl.sv
// Memory-mapped RAM window with sized little-endian access, wait states and error response.
// Optional build macro: MEM_ALIGN_CHECK_EN (reject misaligned accesses instead of aligning them).
module mem_region_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [63:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int          DEPTH     = 2 ** (ADDR_WIDTH - 3);
  localparam logic [31:0] HIT_MASK  = 32'hFFFFFFFF << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [3:0]            wait_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]            size_reg;
  logic [63:0]           wdata_reg;
  logic                  write_reg;
  logic                  err_reg;
  logic [63:0]           rdata_reg;
  logic                  ready_reg, error_reg, busy_reg;

  logic                  hit, accept, req_err;
  logic [2:0]            align_mask;
  logic [ADDR_WIDTH-1:0] cap_addr;

  assign hit    = (address & HIT_MASK) == BASE_ADDR;
  assign accept = (state_reg == IDLE) && hit && (mem_read | mem_write);

  always_comb begin
    align_mask = 3'b000;
    case (size)
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  // Low address bits below the access size are dropped so every access is naturally aligned.
  assign cap_addr = address[ADDR_WIDTH-1:0] & ~{{(ADDR_WIDTH-3){1'b0}}, align_mask};

`ifdef MEM_ALIGN_CHECK_EN
  assign req_err = (mem_read & mem_write) | (|(address[2:0] & align_mask));
`else
  assign req_err = mem_read & mem_write;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt_reg == 4'd0) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath for the captured request
  logic [ADDR_WIDTH-4:0] word_idx;
  logic [5:0]            lane_shift;
  logic [7:0]            be_base, be;
  logic [63:0]           size_mask, wdata_sh, rd_word, rdata_next;
  logic                  mem_we;

  assign word_idx   = addr_reg[ADDR_WIDTH-1:3];
  assign lane_shift = {addr_reg[2:0], 3'b000};

  always_comb begin
    be_base   = 8'h01;
    size_mask = 64'h00000000000000FF;
    case (size_reg)
      2'd1:    begin be_base = 8'h03; size_mask = 64'h000000000000FFFF; end
      2'd2:    begin be_base = 8'h0F; size_mask = 64'h00000000FFFFFFFF; end
      2'd3:    begin be_base = 8'hFF; size_mask = 64'hFFFFFFFFFFFFFFFF; end
      default: begin be_base = 8'h01; size_mask = 64'h00000000000000FF; end
    endcase
  end

  assign be         = be_base << addr_reg[2:0];
  assign wdata_sh   = wdata_reg << lane_shift;
  assign rdata_next = (rd_word >> lane_shift) & size_mask;
  assign mem_we     = (state_reg == ACCESS) && write_reg && !err_reg;

  // One byte-wide array per lane gives independent byte write enables; contents are not reset.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clock) begin
        if (mem_we && be[gi]) lane_mem[word_idx] <= wdata_sh[gi*8 +: 8];
      end

      assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      size_reg     <= 2'd0;
      wdata_reg    <= 64'd0;
      write_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= 64'd0;
      ready_reg    <= 1'b0;
      error_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= cap_addr;
        size_reg     <= size;
        wdata_reg    <= wdata;
        write_reg    <= mem_write;
        err_reg      <= req_err;
        wait_cnt_reg <= WAIT_INIT;
      end else if (state_reg == WAIT && wait_cnt_reg != 4'd0) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
      if (state_reg == ACCESS && !write_reg && !err_reg) rdata_reg <= rdata_next;
      ready_reg <= (state_next == RESP);
      error_reg <= (state_next == RESP) && err_reg;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign error = error_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Scoreboard bench for mem_region_ctrl: directed requests push expectations, a monitor checks on ready.
// Honours MEM_ALIGN_CHECK_EN to select the expected misaligned-access behaviour.
module tb_mem_region_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address = 32'd0;
  logic [63:0] wdata = 64'd0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [63:0] rdata;
  logic        ready, error, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  mem_region_ctrl #(
    .BASE_ADDR  (32'h00001000),
    .ADDR_WIDTH (8),
    .WAIT_STATES(1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .address  (address),
    .wdata    (wdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .size     (size),
    .rdata    (rdata),
    .ready    (ready),
    .error    (error),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && error && !ready) chk("error_without_ready", {63'd0, error}, 64'd0);
      if (ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_rdata"}, rdata, e.rdata);
          chk({e.name, "_error"}, {63'd0, error}, {63'd0, e.err});
          chk({e.name, "_latency"}, 64'(cyc + 1 - e.acc_cyc), 64'd3);
          $display("txn %s rdata=%h error=%0b latency=%0d", e.name, rdata, error, cyc + 1 - e.acc_cyc);
        end
      end
    end
  end

  task automatic do_req(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    bit   done;
    @(negedge clock);
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    address   = addr;
    wdata     = wd;
    @(posedge clock);
    #1;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.acc_cyc = cyc;
    e.name    = name;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_misalign_rd;
    logic        exp_misalign_err;
    logic [63:0] exp_final_rd;
`ifdef MEM_ALIGN_CHECK_EN
    exp_misalign_rd  = 64'h00000000AB667788;
    exp_misalign_err = 1'b1;
    exp_final_rd     = 64'hCAFEBABEDEADBEEF;
`else
    exp_misalign_rd  = 64'h0000000089ABCDEF;
    exp_misalign_err = 1'b0;
    exp_final_rd     = 64'hCAFEBABE1234BEEF;
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {rdata[60:0], ready, error, busy}, 64'd0);
    chk("reset_rdata_hi", {61'd0, rdata[63:61]}, 64'd0);
    reset_n = 1'b1;

    do_req("w64_1008", 1'b0, 1'b1, 2'd3, 32'h1008, 64'h1122334455667788, 64'h0, 1'b0);
    do_req("r64_1008", 1'b1, 1'b0, 2'd3, 32'h1008, 64'h0, 64'h1122334455667788, 1'b0);
    do_req("w8_100b",  1'b0, 1'b1, 2'd0, 32'h100B, 64'hAB, 64'h1122334455667788, 1'b0);
    do_req("r32_1008", 1'b1, 1'b0, 2'd2, 32'h1008, 64'h0, 64'h00000000AB667788, 1'b0);

    // Out-of-window read held for 10 cycles must be ignored entirely.
    @(negedge clock);
    mem_read = 1'b1;
    size     = 2'd3;
    address  = 32'h1100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("miss_flags", {61'd0, busy, ready, error}, 64'd0);
      chk("miss_rdata", rdata, 64'h00000000AB667788);
    end
    $display("txn miss_1100 busy=%0b ready=%0b error=%0b", busy, ready, error);
    mem_read = 1'b0;

    do_req("w64_1000",  1'b0, 1'b1, 2'd3, 32'h1000, 64'h0123456789ABCDEF, 64'h00000000AB667788, 1'b0);
    do_req("r32_1002",  1'b1, 1'b0, 2'd2, 32'h1002, 64'h0, exp_misalign_rd, exp_misalign_err);
    do_req("r16_100a",  1'b1, 1'b0, 2'd1, 32'h100A, 64'h0, 64'h000000000000AB66, 1'b0);
    do_req("r8_100f",   1'b1, 1'b0, 2'd0, 32'h100F, 64'h0, 64'h0000000000000011, 1'b0);
    do_req("w64_1010",  1'b0, 1'b1, 2'd3, 32'h1010, 64'hCAFEBABEDEADBEEF, 64'h11, 1'b0);
    do_req("rw_1010",   1'b1, 1'b1, 2'd3, 32'h1010, 64'h0, 64'h11, 1'b1);
    do_req("r64_1010a", 1'b1, 1'b0, 2'd3, 32'h1010, 64'h0, 64'hCAFEBABEDEADBEEF, 1'b0);

    // Write aborted by reset while waiting must leave memory untouched.
    @(negedge clock);
    mem_write = 1'b1;
    size      = 2'd3;
    address   = 32'h1010;
    wdata     = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clock);
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {rdata[60:0], ready, error, busy}, 64'd0);
    chk("abort_rdata_hi", {61'd0, rdata[63:61]}, 64'd0);
    $display("txn reset_abort rdata=%h ready=%0b error=%0b busy=%0b", rdata, ready, error, busy);
    mem_write = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    do_req("r64_1010b", 1'b1, 1'b0, 2'd3, 32'h1010, 64'h0, 64'hCAFEBABEDEADBEEF, 1'b0);
    do_req("w16_1013",  1'b0, 1'b1, 2'd1, 32'h1013, 64'h1234, 64'hCAFEBABEDEADBEEF, exp_misalign_err);
    do_req("r64_1010c", 1'b1, 1'b0, 2'd3, 32'h1010, 64'h0, exp_final_rd, 1'b0);

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
